// File: rtl/ctx_mover_if.sv
// ---------------------------------------------------------------------------
// ctx_mover_if
// Bundles every handshake and register-file signal of the context mover so
// the mover and its surroundings connect through one port.
//
// Command side   : start, op, task_id (task bank), abort -> busy, done
// Reg-file read  : rf_r_ts, rf_ra_sel -> rf_ra_val (combinational return)
// Reg-file write : rf_ws, rf_w_ts, rf_rd_sel, rf_rd_val
// Save stream    : out_valid, out_data -> out_ready
// Restore stream : in_valid, in_data -> in_ready
//
// The mover drives the register file as initiator, so it uses the master
// modport; the controller / register file / stream peers use slave.
// ---------------------------------------------------------------------------
interface ctx_mover_if #(
    parameter int DW   = 16,
    parameter int SELW = 4
);
    // Command interface
    logic            start;
    logic            op;
    logic            task_id;
    logic            abort;
    logic            busy;
    logic            done;
    // Register-file read port A
    logic            rf_r_ts;
    logic [SELW-1:0] rf_ra_sel;
    logic [DW-1:0]   rf_ra_val;
    // Register-file write port
    logic            rf_ws;
    logic            rf_w_ts;
    logic [SELW-1:0] rf_rd_sel;
    logic [DW-1:0]   rf_rd_val;
    // Save word stream
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    // Restore word stream
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;

    modport master (
        input  start, op, task_id, abort,
        output busy, done,
        output rf_r_ts, rf_ra_sel,
        input  rf_ra_val,
        output rf_ws, rf_w_ts, rf_rd_sel, rf_rd_val,
        output out_valid, out_data,
        input  out_ready,
        input  in_valid, in_data,
        output in_ready
    );

    modport slave (
        output start, op, task_id, abort,
        input  busy, done,
        input  rf_r_ts, rf_ra_sel,
        output rf_ra_val,
        input  rf_ws, rf_w_ts, rf_rd_sel, rf_rd_val,
        input  out_valid, out_data,
        output out_ready,
        output in_valid, in_data,
        input  in_ready
    );
endinterface

// File: rtl/ctx_mover.sv
// ---------------------------------------------------------------------------
// ctx_mover
// Task-context save/restore engine. SAVE reads every register of one task
// bank through read port A and streams the words out (valid/ready) in order
// r0..r(NREGS-1). RESTORE accepts a valid/ready word stream and writes it
// into one task bank through the write port. A one-cycle done pulse marks
// normal completion; abort returns to IDLE without done.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - ctx_mover_if.master: command, reg-file and stream signals
// ---------------------------------------------------------------------------
module ctx_mover #(
    parameter int DW    = 16,
    parameter int SELW  = 4,
    parameter int NREGS = 16
) (
    input  logic            clk,
    input  logic            rst,
    ctx_mover_if.master     bus
);
    // One extra bit so a full 2^SELW bank terminates without wrapping.
    localparam int            CW       = SELW + 1;
    localparam logic [CW-1:0] IDX_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] IDX_ONE  = {{SELW{1'b0}}, 1'b1};
    localparam logic [CW-1:0] IDX_NUM  = CW'(NREGS);
    localparam logic [CW-1:0] IDX_LAST = CW'(NREGS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAVE    = 2'd1,
        ST_RESTORE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t          state_q,     state_d;
    logic            task_q,      task_d;
    logic [CW-1:0]   rd_idx_q,    rd_idx_d;
    logic [CW-1:0]   cnt_q,       cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q,  out_data_d;
    logic            in_ready_q,  in_ready_d;
    logic            busy_q,      busy_d;
    logic            done_q,      done_d;

    logic            load_s;
    logic            xfer_s;
    logic            acc_s;

    // Next-state and datapath decisions for every state.
    always_comb begin
        state_d     = state_q;
        task_d      = task_q;
        rd_idx_d    = rd_idx_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        load_s      = 1'b0;
        xfer_s      = 1'b0;
        acc_s       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The op bit is captured by which state is entered.
                if (bus.start) begin
                    task_d   = bus.task_id;
                    rd_idx_d = IDX_ZERO;
                    cnt_d    = IDX_ZERO;
                    state_d  = bus.op ? ST_RESTORE : ST_SAVE;
                end else begin
                    state_d  = ST_IDLE;
                end
            end

            ST_SAVE: begin
                if (bus.abort) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    xfer_s = out_valid_q & bus.out_ready;
                    // Refill the output register whenever it is empty or
                    // being drained this cycle, until the bank is exhausted.
                    load_s = (rd_idx_q < IDX_NUM) & (~out_valid_q | bus.out_ready);
                    if (load_s) begin
                        out_data_d  = bus.rf_ra_val;
                        out_valid_d = 1'b1;
                        rd_idx_d    = rd_idx_q + IDX_ONE;
                    end else if (xfer_s) begin
                        out_valid_d = 1'b0;
                    end else begin
                        out_valid_d = out_valid_q;
                    end
                    if (xfer_s) begin
                        cnt_d   = cnt_q + IDX_ONE;
                        state_d = (cnt_q == IDX_LAST) ? ST_DONE : ST_SAVE;
                    end else begin
                        state_d = ST_SAVE;
                    end
                end
            end

            ST_RESTORE: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_s = bus.in_valid & in_ready_q;
                    if (acc_s) begin
                        cnt_d   = cnt_q + IDX_ONE;
                        state_d = (cnt_q == IDX_LAST) ? ST_DONE : ST_RESTORE;
                    end else begin
                        state_d = ST_RESTORE;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        // Status outputs are registered copies of the upcoming state.
        in_ready_d = (state_d == ST_RESTORE);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            task_q      <= 1'b0;
            rd_idx_q    <= IDX_ZERO;
            cnt_q       <= IDX_ZERO;
            out_valid_q <= 1'b0;
            out_data_q  <= {DW{1'b0}};
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            task_q      <= task_d;
            rd_idx_q    <= rd_idx_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rf_r_ts   = task_q;
    assign bus.rf_ra_sel = rd_idx_q[SELW-1:0];
    // Write strobe is combinational so an accepted word lands the same edge;
    // acc_s is already suppressed during abort and outside RESTORE.
    assign bus.rf_ws     = acc_s;
    assign bus.rf_w_ts   = task_q;
    assign bus.rf_rd_sel = cnt_q[SELW-1:0];
    assign bus.rf_rd_val = bus.in_data;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.in_ready  = in_ready_q;
endmodule

// File: tb/tb_ctx_mover.sv
module tb_ctx_mover;
    localparam int DW    = 16;
    localparam int SELW  = 4;
    localparam int NREGS = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    ctx_mover_if #(.DW(DW), .SELW(SELW)) bus();

    ctx_mover #(.DW(DW), .SELW(SELW), .NREGS(NREGS)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    // Register file seen by the DUT, and the reference copy of what it should hold.
    logic [DW-1:0] rf_mem [2][NREGS];
    logic [DW-1:0] rf_ref [2][NREGS];

    assign bus.rf_ra_val = rf_mem[bus.rf_r_ts][bus.rf_ra_sel];

    always @(posedge clk) begin
        if (bus.rf_ws) rf_mem[bus.rf_w_ts][bus.rf_rd_sel] = bus.rf_rd_val;
    end

    typedef struct packed {
        logic            ts;
        logic [SELW-1:0] sel;
        logic [DW-1:0]   val;
    } wr_t;

    logic [DW-1:0] sv_got[$];
    wr_t           wr_got[$];
    int            done_cnt = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stream / write monitor sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                chk("stall_valid", 32'(bus.out_valid), 32'd1);
                chk("stall_data", 32'(bus.out_data), 32'(prev_data));
            end
            if (bus.out_valid && bus.out_ready) sv_got.push_back(bus.out_data);
            if (bus.rf_ws) begin
                wr_got.push_back({bus.rf_w_ts, bus.rf_rd_sel, bus.rf_rd_val});
                chk("ws_only_in_restore", 32'(bus.busy & bus.in_ready & ~bus.done), 32'd1);
            end
            if (bus.done) done_cnt++;
            prev_stall = bus.out_valid & ~bus.out_ready & ~bus.abort;
            prev_data  = bus.out_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic o, input logic t);
        bus.start = 1'b1; bus.op = o; bus.task_id = t;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic check_banks(input string name);
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < NREGS; i++)
                chk($sformatf("%s_b%0d_r%0d", name, b, i), 32'(rf_mem[b][i]), 32'(rf_ref[b][i]));
    endtask

    // mode 0: out_ready always 1; 1: pattern 1,0,0,1; 2: random
    task automatic run_save(input logic t, input int mode);
        int d0 = done_cnt;
        int cyc = 0;
        sv_got.delete();
        bus.out_ready = 1'b1;
        start_cmd(1'b0, t);
        while (done_cnt == d0 && cyc < 400) begin
            if (mode == 0)      bus.out_ready = 1'b1;
            else if (mode == 1) bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            else                bus.out_ready = ($urandom % 3) != 0;
            tick();
            cyc++;
        end
        bus.out_ready = 1'b1;
        chk("save_timeout", 32'(cyc < 400), 32'd1);
        chk("save_count", 32'(sv_got.size()), 32'(NREGS));
        for (int i = 0; i < NREGS && i < sv_got.size(); i++)
            chk($sformatf("save_word%0d", i), 32'(sv_got[i]), 32'(rf_ref[t][i]));
        tick(); tick();
        chk("save_done_once", 32'(done_cnt - d0), 32'd1);
        chk("save_idle", 32'(bus.busy), 32'd0);
    endtask

    // mode 0: data 0xA000+i with one-cycle gaps; 1: random data and gaps.
    // inject >= 0 pulses a conflicting SAVE command at that cycle.
    task automatic run_restore(input logic t, input int mode, input int inject);
        logic [DW-1:0] data [NREGS];
        int   d0 = done_cnt;
        int   idx = 0;
        int   cyc = 0;
        logic acc;
        wr_t  e;
        for (int i = 0; i < NREGS; i++) data[i] = (mode == 0) ? 16'hA000 + 16'(i) : 16'($urandom);
        wr_got.delete();
        start_cmd(1'b1, t);
        while (done_cnt == d0 && cyc < 400) begin
            bus.in_valid = (idx < NREGS) && ((mode == 0) ? (cyc % 2 == 0) : ($urandom % 2 == 0));
            if (idx < NREGS) bus.in_data = data[idx];
            if (cyc == inject) begin
                bus.start = 1'b1; bus.op = 1'b0; bus.task_id = ~t;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            acc = bus.in_valid & bus.in_ready;
            tick();
            if (acc) idx++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        chk("restore_timeout", 32'(cyc < 400), 32'd1);
        chk("restore_count", 32'(wr_got.size()), 32'(NREGS));
        for (int i = 0; i < NREGS && i < wr_got.size(); i++) begin
            e.ts = t; e.sel = i[SELW-1:0]; e.val = data[i];
            chk($sformatf("restore_write%0d", i), 32'(wr_got[i]), 32'(e));
        end
        for (int i = 0; i < NREGS; i++) rf_ref[t][i] = data[i];
        tick(); tick();
        chk("restore_done_once", 32'(done_cnt - d0), 32'd1);
        chk("restore_in_ready_low", 32'(bus.in_ready), 32'd0);
        check_banks("readback");
    endtask

    typedef struct packed {
        logic          start, op, tsk, abort;
        logic          e_busy, e_done, e_valid, e_ws;
        logic [DW-1:0] e_data;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        vec_t vt [22];
        vec_t v;
        logic [DW-1:0] rdata [NREGS];
        int   S;
        int   d0;
        int   cyc;

        bus.start = 1'b0; bus.op = 1'b0; bus.task_id = 1'b0; bus.abort = 1'b0;
        bus.out_ready = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
        for (int i = 0; i < NREGS; i++) begin
            rf_mem[0][i] = 16'h0B00 + 16'(i);
            rf_mem[1][i] = 16'h1100 + 16'(i);
            rf_ref[0][i] = rf_mem[0][i];
            rf_ref[1][i] = rf_mem[1][i];
        end

        // Reset state
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_rf_ws", 32'(bus.rf_ws), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_ra_sel", 32'(bus.rf_ra_sel), 32'd0);
        chk("rst_rd_sel", 32'(bus.rf_rd_sel), 32'd0);
        chk("rst_r_ts", 32'(bus.rf_r_ts), 32'd0);
        chk("rst_w_ts", 32'(bus.rf_w_ts), 32'd0);
        tick();

        // Cycle-exact SAVE of task 1: abort in IDLE, start ignored while busy,
        // start+abort in DONE ignored.
        S = 1;
        for (int c = 0; c < 22; c++) begin
            v = '0;
            v.e_busy  = (c >= S + 1) && (c <= S + 18);
            v.e_done  = (c == S + 18);
            v.e_valid = (c >= S + 2) && (c <= S + 17);
            v.e_data  = v.e_valid ? 16'h1100 + 16'(c - S - 2) : 16'h0000;
            vt[c] = v;
        end
        vt[0].abort = 1'b1;
        vt[S].start = 1'b1; vt[S].op = 1'b0; vt[S].tsk = 1'b1;
        vt[S + 5].start = 1'b1; vt[S + 5].op = 1'b1; vt[S + 5].tsk = 1'b0;
        vt[S + 18].start = 1'b1; vt[S + 18].abort = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 22; c++) begin
            bus.start = vt[c].start; bus.op = vt[c].op;
            bus.task_id = vt[c].tsk; bus.abort = vt[c].abort;
            #1;
            chk($sformatf("t1_busy_c%0d", c), 32'(bus.busy), 32'(vt[c].e_busy));
            chk($sformatf("t1_done_c%0d", c), 32'(bus.done), 32'(vt[c].e_done));
            chk($sformatf("t1_valid_c%0d", c), 32'(bus.out_valid), 32'(vt[c].e_valid));
            chk($sformatf("t1_ws_c%0d", c), 32'(bus.rf_ws), 32'(vt[c].e_ws));
            if (vt[c].e_valid)
                chk($sformatf("t1_data_c%0d", c), 32'(bus.out_data), 32'(vt[c].e_data));
            tick();
        end
        bus.start = 1'b0; bus.abort = 1'b0;

        // SAVE with backpressure pattern 1,0,0,1
        run_save(1'b1, 1);

        // RESTORE task 0 with one-cycle in_valid gaps
        run_restore(1'b0, 0, -1);

        // Abort SAVE after 5 transfers, then restart from r0
        d0 = done_cnt; cyc = 0;
        sv_got.delete();
        bus.out_ready = 1'b1;
        start_cmd(1'b0, 1'b1);
        while (sv_got.size() < 5 && cyc < 50) begin tick(); cyc++; end
        chk("abort_wait_timeout", 32'(cyc < 50), 32'd1);
        bus.abort = 1'b1; bus.out_ready = 1'b0;
        tick();
        bus.abort = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        tick(); tick();
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        chk("abort_words", 32'(sv_got.size()), 32'd5);
        run_save(1'b1, 0);

        // RESTORE task 0 while a conflicting SAVE task 1 command is pulsed
        run_restore(1'b0, 1, 3);

        // Asynchronous reset mid-RESTORE after 7 writes
        for (int i = 0; i < NREGS; i++) rdata[i] = 16'($urandom);
        d0 = done_cnt; cyc = 0;
        wr_got.delete();
        start_cmd(1'b1, 1'b1);
        bus.in_valid = 1'b1;
        while (wr_got.size() < 7 && cyc < 50) begin
            bus.in_data = rdata[wr_got.size()];
            tick();
            cyc++;
        end
        chk("rst_wait_timeout", 32'(cyc < 50), 32'd1);
        bus.in_data = rdata[7];
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("mid_rst_rf_ws", 32'(bus.rf_ws), 32'd0);
        chk("mid_rst_rd_sel", 32'(bus.rf_rd_sel), 32'd0);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        bus.in_valid = 1'b0;
        tick(); tick();
        chk("mid_rst_writes", 32'(wr_got.size()), 32'd7);
        chk("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
        for (int i = 0; i < 7; i++) rf_ref[1][i] = rdata[i];
        check_banks("after_rst");

        // Randomized operations against the reference register image
        for (int k = 0; k < 6; k++) begin
            if ($urandom % 2 == 0) run_save(1'($urandom % 2), 2);
            else                   run_restore(1'($urandom % 2), 1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
